cl_frame_to_axis: RTL

//   Consumes the 28-bit Camera Link base-config word {spare, DVAL, FVAL, LVAL, pixel[23:0]} on CL_clk.

---
 rtl/cl_pkg.sv | 17 +
 rtl/cl_sat_counter.sv | 22 ++
 rtl/cl_frame_to_axis.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cl_pkg.sv
// Shared Camera Link definitions: base-config word layout and frame-tracking FSM encoding.
package cl_pkg;

   localparam int unsigned CL_WORD_W    = 28;
   localparam int unsigned CL_PIX_W     = 24;
   localparam int unsigned CL_LVAL_BIT  = 24;
   localparam int unsigned CL_FVAL_BIT  = 25;
   localparam int unsigned CL_DVAL_BIT  = 26;
   localparam int unsigned CL_SPARE_BIT = 27;

   typedef enum logic [1:0] {
      ST_SYNC       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_IN_FRAME   = 2'd2
   } cl_state_e;

endpackage

// File: rtl/cl_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with inc restarts at one.
module cl_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= WIDTH'(inc);
      end else if (inc && !(&q)) begin
         q <= q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cl_frame_to_axis.sv
// Camera Link base-config word to AXI4-Stream video (tuser = SOF, tlast = EOL),
// with line/frame geometry measurement and sticky overflow / width-mismatch flags.
module cl_frame_to_axis
   import cl_pkg::*;
#(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                 CL_clk,
   input  logic                 CL_rst,
   input  logic [CL_WORD_W-1:0] CL_data,
   output logic [DATA_W-1:0]    m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tuser,
   output logic                 m_axis_tlast,
   output logic [CNT_W-1:0]     line_width,
   output logic [CNT_W-1:0]     frame_height,
   output logic [31:0]          frame_cnt,
   output logic                 in_frame,
   output logic                 err_overflow,
   output logic                 err_width,
   input  logic                 err_clr
);

   cl_state_e          state, state_nxt;

   logic [DATA_W-1:0]  r_pix;
   logic               r_lval, r_fval, r_dval, r_vld;
   logic               p_lval, p_fval;

   logic [DATA_W-1:0]  hold;
   logic               hold_vld;
   logic               sof_pend;
   logic [CNT_W-1:0]   ref_w;
   logic [CNT_W-1:0]   px_cnt, ln_cnt;

   logic               pix_c, fval_rise_c, fval_fall_c, lval_fall_c;
   logic               load_c, close_c, emit_c, last_c, enter_c, frame_end_c;
   logic               line_done_c, width_err_c, ovf_c;
   logic [CNT_W-1:0]   ln_total_c;

   // Spare bit and any pixel bits above DATA_W are intentionally dropped.
   logic               unused_bits;
   assign unused_bits = ^{CL_data[CL_SPARE_BIT], CL_data[CL_PIX_W-1:0]};

   // Input capture plus one-deep history for edge detection.
   always_ff @(posedge CL_clk) begin
      if (CL_rst) begin
         r_pix  <= '0;
         r_lval <= 1'b0;
         r_fval <= 1'b0;
         r_dval <= 1'b0;
         r_vld  <= 1'b0;
         p_lval <= 1'b0;
         p_fval <= 1'b0;
      end else begin
         r_pix  <= CL_data[DATA_W-1:0];
         r_lval <= CL_data[CL_LVAL_BIT];
         r_fval <= CL_data[CL_FVAL_BIT];
         r_dval <= CL_data[CL_DVAL_BIT];
         r_vld  <= 1'b1;
         p_lval <= r_lval;
         p_fval <= r_fval;
      end
   end

   assign pix_c       = r_fval & r_lval & r_dval;
   assign fval_rise_c = r_fval & ~p_fval;
   assign fval_fall_c = p_fval & ~r_fval;
   assign lval_fall_c = p_lval & ~r_lval;

   always_ff @(posedge CL_clk) begin
      if (CL_rst) begin
         state <= ST_SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-sample beat decisions; r_vld keeps SYNC from trusting the reset value of r_fval.
   always_comb begin
      state_nxt   = state;
      load_c      = 1'b0;
      close_c     = 1'b0;
      emit_c      = 1'b0;
      last_c      = 1'b0;
      enter_c     = 1'b0;
      frame_end_c = 1'b0;
      case (state)
         ST_SYNC: begin
            if (r_vld && !r_fval) begin
               state_nxt = ST_WAIT_FRAME;
            end
         end
         ST_WAIT_FRAME: begin
            if (fval_rise_c) begin
               state_nxt = ST_IN_FRAME;
               enter_c   = 1'b1;
               load_c    = pix_c;
            end
         end
         ST_IN_FRAME: begin
            if (pix_c) begin
               load_c = 1'b1;
               emit_c = hold_vld;
            end else if (lval_fall_c || fval_fall_c) begin
               close_c = 1'b1;
               emit_c  = hold_vld;
               last_c  = hold_vld;
            end
            if (fval_fall_c) begin
               frame_end_c = 1'b1;
               state_nxt   = ST_WAIT_FRAME;
            end
         end
         default: begin
            state_nxt = ST_SYNC;
         end
      endcase
   end

   // A close only counts as a line when at least one pixel was held.
   assign line_done_c = close_c & hold_vld;
   assign width_err_c = line_done_c && (ln_cnt != '0) && (px_cnt != ref_w);
   assign ln_total_c  = !line_done_c ? ln_cnt :
                        (&ln_cnt)    ? ln_cnt : ln_cnt + CNT_W'(1);
   assign ovf_c       = m_axis_tvalid & ~m_axis_tready;

   cl_sat_counter #(.WIDTH(CNT_W)) u_px_cnt (
      .clk (CL_clk),
      .rst (CL_rst),
      .clr (close_c | enter_c),
      .inc (load_c),
      .q   (px_cnt)
   );

   cl_sat_counter #(.WIDTH(CNT_W)) u_ln_cnt (
      .clk (CL_clk),
      .rst (CL_rst),
      .clr (enter_c),
      .inc (line_done_c),
      .q   (ln_cnt)
   );

   // Hold register, stream outputs, geometry and error flags.
   always_ff @(posedge CL_clk) begin
      if (CL_rst) begin
         hold          <= '0;
         hold_vld      <= 1'b0;
         sof_pend      <= 1'b0;
         ref_w         <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
         line_width    <= '0;
         frame_height  <= '0;
         frame_cnt     <= '0;
         in_frame      <= 1'b0;
         err_overflow  <= 1'b0;
         err_width     <= 1'b0;
      end else begin
         if (load_c) begin
            hold     <= r_pix;
            hold_vld <= 1'b1;
         end else if (close_c) begin
            hold_vld <= 1'b0;
         end

         if (enter_c) begin
            sof_pend <= 1'b1;
         end else if (emit_c) begin
            sof_pend <= 1'b0;
         end

         m_axis_tvalid <= emit_c;
         m_axis_tuser  <= emit_c & sof_pend;
         m_axis_tlast  <= last_c;
         if (emit_c) begin
            m_axis_tdata <= hold;
         end

         if (line_done_c) begin
            line_width <= px_cnt;
            if (ln_cnt == '0) begin
               ref_w <= px_cnt;
            end
         end

         if (frame_end_c) begin
            frame_cnt <= frame_cnt + 32'd1;
            if (ln_total_c != '0) begin
               frame_height <= ln_total_c;
            end
         end

         in_frame     <= (state_nxt == ST_IN_FRAME);
         err_overflow <= (err_overflow & ~err_clr) | ovf_c;
         err_width    <= (err_width & ~err_clr) | width_err_c;
      end
   end

endmodule
